// File: rtl/trb_pkg.sv
// Shared types for the turbo byte-stream to cache-line packer.
package trb_pkg;

    localparam int LINE_BYTES = 64;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int ST_LEN     = 128;

    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic              sop;
        logic              eop;
    } trb_line_t;

    typedef enum logic [1:0] {IDLE, FILL, DROP} trb_state_e;

    function automatic logic [LINE_W-1:0] put_byte(input logic [LINE_W-1:0] line,
                                                   input logic [5:0]        lane,
                                                   input logic [7:0]        b);
        logic [LINE_W-1:0] r;
        r = line;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/trb_line_fifo.sv
// Two-entry register FIFO holding completed cache lines; head is always visible.
module trb_line_fifo
    import trb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  trb_line_t push_line_i,
    input  logic      pop_i,
    output trb_line_t head_o,
    output logic [1:0] count_o
);

    trb_line_t  mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] count_q;
    logic [1:0] count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_line_i;
                wr_q        <= ~wr_q;
            end
            if (pop_i) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/trb_line_packer.sv
// Packs sop/eop-framed turbo bytes into 512-bit lines, checks framing, buffers two lines.
module trb_line_packer
    import trb_pkg::*;
#(
    parameter int FRAME_BYTES = ST_LEN,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        st_data_in,
    input  logic              st_valid_in,
    input  logic              st_sop_in,
    input  logic              st_eop_in,
    output logic              st_ready_out,
    output logic [LINE_W-1:0] line_data,
    output logic              line_valid,
    output logic              line_sop,
    output logic              line_eop,
    output logic [ADDR_W-1:0] line_addr,
    input  logic              line_ready,
    output logic [15:0]       frame_cnt,
    output logic              err_len,
    output logic              err_sop,
    output logic              err_ovf
);

    localparam int               CNT_W    = $clog2(FRAME_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    trb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] asm_q, asm_d;
    logic              first_q, first_d;
    logic [15:0]       frame_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_len_q, err_sop_q, err_ovf_q;

    logic [LINE_W-1:0] fresh, filled;
    logic              last_byte, last_lane;
    logic              accept, pop, push;
    logic              frame_inc, set_len, set_sop;
    trb_line_t         push_line, head;
    logic [1:0]        count;

    assign st_ready_out = (count != 2'd2);
    assign accept       = st_valid_in & st_ready_out;
    assign line_valid   = (count != 2'd0);
    assign pop          = line_valid & line_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        first_d   = first_q;
        push      = 1'b0;
        push_line = '0;
        frame_inc = 1'b0;
        set_len   = 1'b0;
        set_sop   = 1'b0;
        fresh     = put_byte('0, 6'd0, st_data_in);
        filled    = put_byte(asm_q, cnt_q[5:0], st_data_in);
        last_byte = (cnt_q == LAST_IDX);
        last_lane = (cnt_q[5:0] == 6'd63);
        if (accept) begin
            case (state_q)
                IDLE, DROP: begin
                    if (st_sop_in && st_eop_in) begin
                        // Single-byte frame: always short, emitted as one padded line.
                        push           = 1'b1;
                        push_line.data = fresh;
                        push_line.sop  = 1'b1;
                        push_line.eop  = 1'b1;
                        frame_inc      = 1'b1;
                        set_len        = 1'b1;
                        asm_d          = '0;
                        cnt_d          = '0;
                        state_d        = IDLE;
                    end else if (st_sop_in) begin
                        asm_d   = fresh;
                        cnt_d   = CNT_W'(1);
                        first_d = 1'b1;
                        state_d = FILL;
                    end else if (state_q == DROP && st_eop_in) begin
                        state_d = IDLE;
                    end
                end
                FILL: begin
                    if (st_sop_in) begin
                        // Close the running frame and seed a fresh line with the sop byte.
                        push           = 1'b1;
                        push_line.data = asm_q;
                        push_line.sop  = first_q;
                        push_line.eop  = 1'b1;
                        set_sop        = 1'b1;
                        frame_inc      = 1'b1;
                        asm_d          = fresh;
                        cnt_d          = CNT_W'(1);
                        first_d        = 1'b1;
                    end else begin
                        push           = st_eop_in | last_lane;
                        push_line.data = filled;
                        push_line.sop  = first_q;
                        push_line.eop  = st_eop_in | last_byte;
                        asm_d          = push ? '0 : filled;
                        first_d        = push ? 1'b0 : first_q;
                        cnt_d          = cnt_q + CNT_W'(1);
                        if (st_eop_in) begin
                            frame_inc = 1'b1;
                            set_len   = ~last_byte;
                            cnt_d     = '0;
                            state_d   = IDLE;
                        end else if (last_byte) begin
                            frame_inc = 1'b1;
                            set_len   = 1'b1;
                            cnt_d     = '0;
                            state_d   = DROP;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            asm_q       <= '0;
            first_q     <= 1'b0;
            frame_cnt_q <= '0;
            addr_q      <= '0;
            err_len_q   <= 1'b0;
            err_sop_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            first_q     <= first_d;
            frame_cnt_q <= frame_cnt_q + {15'd0, frame_inc};
            addr_q      <= addr_q + {{(ADDR_W-1){1'b0}}, pop};
            err_len_q   <= err_len_q | set_len;
            err_sop_q   <= err_sop_q | set_sop;
            err_ovf_q   <= err_ovf_q | (st_valid_in & ~st_ready_out);
        end
    end

    trb_line_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_line_i (push_line),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign line_data = head.data;
    assign line_sop  = line_valid & head.sop;
    assign line_eop  = line_valid & head.eop;
    assign line_addr = addr_q;
    assign frame_cnt = frame_cnt_q;
    assign err_len   = err_len_q;
    assign err_sop   = err_sop_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_trb_line_packer.sv
// Directed bench for trb_line_packer: expected line tables per scenario, popped lines captured at negedge.
module tb_trb_line_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   st_data_in;
    logic         st_valid_in, st_sop_in, st_eop_in;
    logic         st_ready_out;
    logic [511:0] line_data;
    logic         line_valid, line_sop, line_eop;
    logic [15:0]  line_addr;
    logic         line_ready;
    logic [15:0]  frame_cnt;
    logic         err_len, err_sop, err_ovf;

    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [15:0]  addr;
    } line_rec_t;

    line_rec_t capq[$];
    line_rec_t exp_tab[8];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trb_line_packer #(.FRAME_BYTES(128), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_data_in(st_data_in), .st_valid_in(st_valid_in),
        .st_sop_in(st_sop_in), .st_eop_in(st_eop_in), .st_ready_out(st_ready_out),
        .line_data(line_data), .line_valid(line_valid), .line_sop(line_sop),
        .line_eop(line_eop), .line_addr(line_addr), .line_ready(line_ready),
        .frame_cnt(frame_cnt), .err_len(err_len), .err_sop(err_sop), .err_ovf(err_ovf)
    );

    always @(negedge clk)
        if (rst_n && line_valid && line_ready)
            capq.push_back('{line_data, line_sop, line_eop, line_addr});

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        st_valid_in = 1'b0; st_sop_in = 1'b0; st_eop_in = 1'b0; st_data_in = 8'h00;
        line_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        capq.delete();
    endtask

    task automatic drive(input logic [7:0] d, input logic s, input logic e);
        st_data_in = d; st_sop_in = s; st_eop_in = e; st_valid_in = 1'b1;
        @(posedge clk);
        #1;
        st_valid_in = 1'b0; st_sop_in = 1'b0; st_eop_in = 1'b0;
    endtask

    task automatic cmp_lines(input string tag, input int n);
        int k;
        k = 0;
        while (capq.size() < n && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_nlines"}, capq.size(), n);
        for (int i = 0; i < n && i < capq.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), capq[i].data, exp_tab[i].data);
            check($sformatf("%s_sop%0d", tag, i), capq[i].sop, exp_tab[i].sop);
            check($sformatf("%s_eop%0d", tag, i), capq[i].eop, exp_tab[i].eop);
            check($sformatf("%s_addr%0d", tag, i), capq[i].addr, exp_tab[i].addr);
        end
        capq.delete();
    endtask

    task automatic set_exp(input int idx, input logic s, input logic e);
        exp_tab[idx].sop  = s;
        exp_tab[idx].eop  = e;
        exp_tab[idx].addr = 16'(idx);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state and two back-to-back good frames
        do_reset();
        check("rst_valid", line_valid, 1'b0);
        check("rst_ready", st_ready_out, 1'b1);
        check("rst_data", line_data, '0);
        check("rst_sopeop", {line_sop, line_eop}, 2'b00);
        check("rst_addr", line_addr, 16'd0);
        check("rst_fcnt", frame_cnt, 16'd0);
        check("rst_errs", {err_len, err_sop, err_ovf}, 3'b000);
        for (int k = 0; k < 4; k++) begin
            exp_tab[k] = '0;
            for (int j = 0; j < 64; j++) exp_tab[k].data[8*j +: 8] = 8'((k % 2) * 64 + j);
            set_exp(k, (k % 2) == 0, (k % 2) == 1);
        end
        line_ready = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 128; i++) drive(8'(i), i == 0, i == 127);
        cmp_lines("t1", 4);
        check("t1_fcnt", frame_cnt, 16'd2);
        check("t1_errs", {err_len, err_sop, err_ovf}, 3'b000);
        check("t1_addr_end", line_addr, 16'd4);

        // Backpressure: FIFO fills, overflow byte dropped, then drain in order
        do_reset();
        for (int k = 0; k < 2; k++) begin
            exp_tab[k] = '0;
            for (int j = 0; j < 64; j++) exp_tab[k].data[8*j +: 8] = 8'(k * 64 + j);
            set_exp(k, k == 0, k == 1);
        end
        for (int i = 0; i < 128; i++) begin
            drive(8'(i), i == 0, i == 127);
            if (i == 62) check("t2_valid_before", line_valid, 1'b0);
            if (i == 63) check("t2_latency", line_valid, 1'b1);
        end
        check("t2_ready_low", st_ready_out, 1'b0);
        check("t2_ovf_before", err_ovf, 1'b0);
        drive(8'hAA, 1'b1, 1'b0);
        check("t2_ovf", err_ovf, 1'b1);
        line_ready = 1'b1;
        cmp_lines("t2", 2);
        check("t2_ready_back", st_ready_out, 1'b1);
        check("t2_fcnt", frame_cnt, 16'd1);
        check("t2_len", err_len, 1'b0);

        // Short frame: eop on byte 99
        do_reset();
        line_ready = 1'b1;
        exp_tab[0] = '0; exp_tab[1] = '0;
        for (int j = 0; j < 64; j++) exp_tab[0].data[8*j +: 8] = 8'(j + 1);
        for (int j = 0; j < 36; j++) exp_tab[1].data[8*j +: 8] = 8'(65 + j);
        set_exp(0, 1'b1, 1'b0);
        set_exp(1, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) drive(8'(i + 1), i == 0, i == 99);
        cmp_lines("t3", 2);
        check("t3_len", err_len, 1'b1);
        check("t3_sop", err_sop, 1'b0);
        check("t3_fcnt", frame_cnt, 16'd1);

        // sop at byte 70 closes the frame and starts a new one with that byte
        do_reset();
        line_ready = 1'b1;
        for (int k = 0; k < 4; k++) exp_tab[k] = '0;
        for (int j = 0; j < 64; j++) begin
            exp_tab[0].data[8*j +: 8] = 8'(j + 1);
            exp_tab[2].data[8*j +: 8] = (j == 0) ? 8'hA5 : 8'(j + 128);
            exp_tab[3].data[8*j +: 8] = 8'(j + 192);
        end
        for (int j = 0; j < 6; j++) exp_tab[1].data[8*j +: 8] = 8'(65 + j);
        set_exp(0, 1'b1, 1'b0);
        set_exp(1, 1'b0, 1'b1);
        set_exp(2, 1'b1, 1'b0);
        set_exp(3, 1'b0, 1'b1);
        for (int i = 0; i < 70; i++) drive(8'(i + 1), i == 0, 1'b0);
        for (int k = 0; k < 128; k++) drive((k == 0) ? 8'hA5 : 8'(k + 128), k == 0, k == 127);
        cmp_lines("t4", 4);
        check("t4_sop", err_sop, 1'b1);
        check("t4_len", err_len, 1'b0);
        check("t4_fcnt", frame_cnt, 16'd2);

        // Missing eop: frame closed at length, trailing bytes dropped, next frame clean
        do_reset();
        line_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_tab[k] = '0;
            for (int j = 0; j < 64; j++)
                exp_tab[k].data[8*j +: 8] = 8'((k % 2) * 64 + j) ^ ((k >= 2) ? 8'h55 : 8'h00);
            set_exp(k, (k % 2) == 0, (k % 2) == 1);
        end
        for (int i = 0; i < 128; i++) drive(8'(i), i == 0, 1'b0);
        check("t5_len_set", err_len, 1'b1);
        for (int i = 0; i < 10; i++) drive(8'hEE, 1'b0, 1'b0);
        check("t5_fcnt_mid", frame_cnt, 16'd1);
        for (int i = 0; i < 128; i++) drive(8'(i) ^ 8'h55, i == 0, i == 127);
        cmp_lines("t5", 4);
        check("t5_fcnt", frame_cnt, 16'd2);
        check("t5_sop", err_sop, 1'b0);

        // Stray bytes in IDLE ignored; sop+eop single-byte frame
        do_reset();
        line_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive(8'h11, 1'b0, 1'b0);
        cmp_lines("t7a", 0);
        check("t7a_errs", {err_len, err_sop, err_ovf}, 3'b000);
        exp_tab[0] = '0;
        exp_tab[0].data[7:0] = 8'h3C;
        set_exp(0, 1'b1, 1'b1);
        drive(8'h3C, 1'b1, 1'b1);
        cmp_lines("t7b", 1);
        check("t7b_len", err_len, 1'b1);
        check("t7b_fcnt", frame_cnt, 16'd1);

        // Asynchronous reset mid-line
        do_reset();
        for (int i = 0; i < 84; i++) drive(8'(i), i == 0, 1'b0);
        check("t6_valid_pre", line_valid, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_valid", line_valid, 1'b0);
        check("t6_data", line_data, '0);
        check("t6_sop", line_sop, 1'b0);
        check("t6_ready", st_ready_out, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        capq.delete();
        line_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_tab[k] = '0;
            for (int j = 0; j < 64; j++) exp_tab[k].data[8*j +: 8] = 8'(k * 64 + j) ^ 8'h33;
            set_exp(k, k == 0, k == 1);
        end
        for (int i = 0; i < 128; i++) drive(8'(i) ^ 8'h33, i == 0, i == 127);
        cmp_lines("t6", 2);
        check("t6_errs", {err_len, err_sop, err_ovf}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
